// File: rtl/reg_bank_rd2_wr1.sv
// 32x32 register bank, two registered read ports, one write port.
// A post-reset sweep clears every entry before the bank reports ready.
module reg_bank_rd2_wr1 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd1_d   = '0;
    rd2_d   = '0;
    we      = 1'b0;
    wa      = cnt_q;
    wd      = '0;
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (cnt_q == '1) state_d = RUN;
        else cnt_d = cnt_q + 1'b1;
      end
      RUN: begin
        we = RegWrite && (WriteReg != '0);
        wa = WriteReg;
        wd = WriteData;
        // Same-edge write is forwarded so the reader sees the new word
        if (ReadReg1 != '0)
          rd1_d = (we && WriteReg == ReadReg1) ?
                  WriteData : mem_q[ReadReg1];
        if (ReadReg2 != '0)
          rd2_d = (we && WriteReg == ReadReg2) ?
                  WriteData : mem_q[ReadReg2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign ready     = (state_q == RUN);

endmodule

// File: tb/tb_reg_bank_rd2_wr1.sv
// Bench for reg_bank_rd2_wr1: vector table plus reset/sweep sequences,
// read results checked through an expected-value queue.
module tb_reg_bank_rd2_wr1;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        ready;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];

  localparam logic [31:0] K = 32'h0101_0101;

  reg_bank_rd2_wr1 dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [31:0] e1,
                     input logic [31:0] e2);
    exp_t x;
    @(negedge clk);
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    ReadReg1  = a1;
    ReadReg2  = a2;
    sb.push_back('{e1, e2});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("rd1", ReadData1, x.e1);
    chk("rd2", ReadData2, x.e2);
  endtask

  task automatic sweep(input bit inject);
    int k;
    k = 0;
    do begin
      k++;
      if (inject && k == 10)
        cyc(1'b1, 5'd3, 32'hAAAA_5555, 5'd3, 5'd3, '0, '0);
      else
        cyc(1'b0, 5'(k), 32'hFFFF_FFFF, 5'(k), 5'(31 - k), '0, '0);
    end while (!ready && k < 40);
    chk("sweep_len", 32'(k), 32'd32);
    chk("ready_after_sweep", {31'b0, ready}, 32'd1);
  endtask

  task automatic read_all(input logic [31:0] m);
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 5'd0, '0, 5'(i), 5'(31 - i),
          m * 32'(i), m * 32'(31 - i));
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd0,
               32'h0, 32'h0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,
               32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,
               32'h0, 32'h0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,
               32'h0, 32'h0};
    vt[4]  = '{1'b1, 5'd9,  32'h1234_5678, 5'd9,  5'd9,
               32'h1234_5678, 32'h1234_5678};
    vt[5]  = '{1'b0, 5'd0,  32'h0,         5'd9,  5'd5,
               32'h1234_5678, 32'hDEAD_BEEF};
    vt[6]  = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,
               32'h0, 32'h0};
    vt[7]  = '{1'b1, 5'd3,  32'h0000_1111, 5'd3,  5'd7,
               32'h0000_1111, 32'h0};
    vt[8]  = '{1'b1, 5'd3,  32'h0000_2222, 5'd3,  5'd3,
               32'h0000_2222, 32'h0000_2222};
    vt[9]  = '{1'b0, 5'd3,  32'h0000_FFFF, 5'd3,  5'd9,
               32'h0000_2222, 32'h1234_5678};
    vt[10] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd0,
               32'h8000_0001, 32'h0};
    vt[11] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd31,
               32'h8000_0001, 32'h8000_0001};

    reset     = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;

    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rd1", ReadData1, 32'h0);
    chk("rst_rd2", ReadData2, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    sweep(1'b1);
    read_all(32'h0);

    for (int i = 0; i < 12; i++)
      cyc(vt[i].we, vt[i].wa, vt[i].wd, vt[i].a1, vt[i].a2,
          vt[i].e1, vt[i].e2);

    for (int i = 1; i < 32; i++)
      cyc(1'b1, 5'(i), K * 32'(i), 5'(i), 5'd0, K * 32'(i), 32'h0);
    read_all(K);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 5'd0, '0, 5'd31, 5'd30, K * 32'd31, K * 32'd30);

    #2;
    reset     = 1'b0;
    RegWrite  = 1'b1;
    WriteReg  = 5'd7;
    WriteData = 32'hFFFF_FFFF;
    #1;
    chk("run_rst_ready", {31'b0, ready}, 32'd0);
    chk("run_rst_rd1", ReadData1, 32'h0);
    chk("run_rst_rd2", ReadData2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    RegWrite = 1'b0;

    for (int i = 0; i < 17; i++)
      cyc(1'b1, 5'd7, 32'h5555_5555, 5'd7, 5'd8, '0, '0);
    chk("mid_sweep_ready", {31'b0, ready}, 32'd0);

    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    sweep(1'b0);
    read_all(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
